reg_file_mwnr: RTL and testbench

Parametrised multi-write, multi-read register file: the general-purpose successor to the fixed 1-write/2-read set, used wherever several producers update hypervector or operand registers and several consumers read them in the same cycle. Adds configurable port counts, a choice of combinational or registered read, same-cycle write-to-read bypass, per-entry "written since clear" tracking and write-collision reporting. Sits between encoder/bundler datapaths and their operand consumers.

---
 rtl/reg_file_mwnr.sv | 153 +++++++++++++++
 tb/tb_reg_file_mwnr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mwnr.sv
// Multi-write / multi-read register file with optional registered read, same-cycle
// write bypass, per-entry "written since clear" flags and a write-collision pulse.
module reg_file_mwnr #(
  parameter int  DataWidth    = 512,
  parameter int  NumRegs      = 8,
  parameter int  NumWrPorts   = 2,
  parameter int  NumRdPorts   = 4,
  parameter int  RegRead      = 1,
  parameter int  WriteBypass  = 1,
  localparam int NumRegsWidth = $clog2(NumRegs)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clr_i,
  input  logic [NumWrPorts-1:0]                   wr_en_i,
  input  logic [NumWrPorts-1:0][NumRegsWidth-1:0] wr_addr_i,
  input  logic [NumWrPorts-1:0][DataWidth-1:0]    wr_data_i,
  input  logic [NumRdPorts-1:0]                   rd_en_i,
  input  logic [NumRdPorts-1:0][NumRegsWidth-1:0] rd_addr_i,
  output logic [NumRdPorts-1:0][DataWidth-1:0]    rd_data_o,
  output logic [NumRdPorts-1:0]                   rd_valid_o,
  output logic [NumRdPorts-1:0]                   rd_written_o,
  output logic                                    collision_o
);

  localparam logic [31:0] NumRegsU  = 32'(NumRegs);
  localparam bit          UseBypass = (RegRead != 0) && (WriteBypass != 0);

  function automatic logic addr_ok(input logic [NumRegsWidth-1:0] addr);
    return ({{(32-NumRegsWidth){1'b0}}, addr} < NumRegsU);
  endfunction

  function automatic logic addr_is(input logic [NumRegsWidth-1:0] addr, input int idx);
    return (addr == NumRegsWidth'(idx));
  endfunction

  logic [DataWidth-1:0] mem_r          [NumRegs];
  logic [NumRegs-1:0]   written_r;
  logic                 win_en_s       [NumRegs];
  logic [DataWidth-1:0] win_data_s     [NumRegs];
  logic                 collision_s;
  logic                 collision_r;
  logic [DataWidth-1:0] look_data_s    [NumRdPorts];
  logic                 look_written_s [NumRdPorts];

  // Per-entry winning write: ports scanned upward so the highest enabled port wins.
  always_comb begin
    for (int e = 0; e < NumRegs; e++) begin
      win_en_s[e]   = 1'b0;
      win_data_s[e] = '0;
    end
    for (int p = 0; p < NumWrPorts; p++) begin
      for (int e = 0; e < NumRegs; e++) begin
        win_data_s[e] = (wr_en_i[p] && addr_is(wr_addr_i[p], e)) ? wr_data_i[p] : win_data_s[e];
        win_en_s[e]   = win_en_s[e] | (wr_en_i[p] & addr_is(wr_addr_i[p], e));
      end
    end
  end

  // Two or more enabled ports on the same in-range address.
  always_comb begin
    collision_s = 1'b0;
    for (int i = 0; i < NumWrPorts; i++) begin
      for (int j = i + 1; j < NumWrPorts; j++) begin
        collision_s = collision_s | (wr_en_i[i] & wr_en_i[j] &
                                     (wr_addr_i[i] == wr_addr_i[j]) & addr_ok(wr_addr_i[i]));
      end
    end
  end

  // Read lookup; out-of-range addresses match no entry and so return zero / unwritten.
  always_comb begin
    for (int r = 0; r < NumRdPorts; r++) begin
      look_data_s[r]    = '0;
      look_written_s[r] = 1'b0;
      for (int e = 0; e < NumRegs; e++) begin
        look_data_s[r]    = !addr_is(rd_addr_i[r], e) ? look_data_s[r] :
                            ((UseBypass && win_en_s[e]) ? win_data_s[e] : mem_r[e]);
        look_written_s[r] = look_written_s[r] |
                            (addr_is(rd_addr_i[r], e) & (written_r[e] | (UseBypass & win_en_s[e])));
      end
    end
  end

  // Entry storage, written flags and collision pulse; clear discards that cycle's writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NumRegs; e++) mem_r[e] <= '0;
      written_r   <= '0;
      collision_r <= 1'b0;
    end else if (clr_i) begin
      for (int e = 0; e < NumRegs; e++) mem_r[e] <= '0;
      written_r   <= '0;
      collision_r <= 1'b0;
    end else begin
      for (int e = 0; e < NumRegs; e++) begin
        if (win_en_s[e]) begin
          mem_r[e]     <= win_data_s[e];
          written_r[e] <= 1'b1;
        end
      end
      collision_r <= collision_s;
    end
  end

  assign collision_o = collision_r;

  if (RegRead != 0) begin : g_reg_read
    logic [DataWidth-1:0]  rd_data_r [NumRdPorts];
    logic [NumRdPorts-1:0] rd_valid_r;
    logic [NumRdPorts-1:0] rd_written_r;

    // Read capture; data and flag hold between requests, valid is a one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int r = 0; r < NumRdPorts; r++) rd_data_r[r] <= '0;
        rd_valid_r   <= '0;
        rd_written_r <= '0;
      end else if (clr_i) begin
        for (int r = 0; r < NumRdPorts; r++) rd_data_r[r] <= '0;
        rd_valid_r   <= '0;
        rd_written_r <= '0;
      end else begin
        rd_valid_r <= rd_en_i;
        for (int r = 0; r < NumRdPorts; r++) begin
          if (rd_en_i[r]) begin
            rd_data_r[r]    <= look_data_s[r];
            rd_written_r[r] <= look_written_s[r];
          end
        end
      end
    end

    // Flatten captured read data onto the output bus.
    always_comb begin
      for (int r = 0; r < NumRdPorts; r++) rd_data_o[r] = rd_data_r[r];
    end

    assign rd_valid_o   = rd_valid_r;
    assign rd_written_o = rd_written_r;
  end else begin : g_comb_read
    // Combinational read straight from storage, no bypass.
    always_comb begin
      for (int r = 0; r < NumRdPorts; r++) begin
        rd_data_o[r]    = look_data_s[r];
        rd_written_o[r] = look_written_s[r];
      end
    end

    assign rd_valid_o = rd_en_i;
  end

endmodule

// File: tb/tb_reg_file_mwnr.sv
// Scoreboard bench: four variants (bypass, no bypass, combinational, 6 entries) share
// stimulus; a behavioural model queues expected read responses checked by a monitor.
module tb_reg_file_mwnr;
  localparam int DW = 512;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 3;
  localparam int ND = 4;

  function automatic int nregs_of(input int k); return (k == 3) ? 6 : 8; endfunction
  function automatic int rr_of(input int k);    return (k == 2) ? 0 : 1; endfunction
  function automatic int wb_of(input int k);    return (k == 1) ? 0 : 1; endfunction

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   clr;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0][AW-1:0]  wr_addr;
  logic [NW-1:0][DW-1:0]  wr_data;
  logic [NR-1:0]          rd_en;
  logic [NR-1:0][AW-1:0]  rd_addr;
  logic [NR-1:0][DW-1:0]  rd_data    [ND];
  logic [NR-1:0]          rd_valid   [ND];
  logic [NR-1:0]          rd_written [ND];
  logic                   coll       [ND];

  always #5 clk = ~clk;

  reg_file_mwnr #(.DataWidth(DW), .NumRegs(8), .NumWrPorts(NW), .NumRdPorts(NR),
                  .RegRead(1), .WriteBypass(1)) u_byp (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]),
    .rd_valid_o(rd_valid[0]), .rd_written_o(rd_written[0]), .collision_o(coll[0]));
  reg_file_mwnr #(.DataWidth(DW), .NumRegs(8), .NumWrPorts(NW), .NumRdPorts(NR),
                  .RegRead(1), .WriteBypass(0)) u_nobyp (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]),
    .rd_valid_o(rd_valid[1]), .rd_written_o(rd_written[1]), .collision_o(coll[1]));
  reg_file_mwnr #(.DataWidth(DW), .NumRegs(8), .NumWrPorts(NW), .NumRdPorts(NR),
                  .RegRead(0), .WriteBypass(1)) u_comb (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]),
    .rd_valid_o(rd_valid[2]), .rd_written_o(rd_written[2]), .collision_o(coll[2]));
  reg_file_mwnr #(.DataWidth(DW), .NumRegs(6), .NumWrPorts(NW), .NumRdPorts(NR),
                  .RegRead(1), .WriteBypass(1)) u_six (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[3]),
    .rd_valid_o(rd_valid[3]), .rd_written_o(rd_written[3]), .collision_o(coll[3]));

  typedef struct {
    int            k;
    int            r;
    int            due;
    logic [DW-1:0] data;
    logic          written;
  } exp_t;

  logic [DW-1:0] m_mem  [ND][8];
  logic          m_wr   [ND][8];
  logic          m_coll [ND];
  exp_t          sb[$];
  exp_t          mon_e;
  bit            seen [ND][NR];
  int            cyc = 0;
  bit            mon_en = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic void check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < ND; k++) begin
      for (int e = 0; e < 8; e++) begin
        m_mem[k][e] = '0;
        m_wr[k][e]  = 1'b0;
      end
      m_coll[k] = 1'b0;
    end
  endfunction

  // Monitor: pop every response due this cycle, flag any valid nobody asked for.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < ND; k++) for (int r = 0; r < NR; r++) seen[k][r] = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        check($sformatf("valid d%0d p%0d", mon_e.k, mon_e.r), DW'(rd_valid[mon_e.k][mon_e.r]), DW'(1));
        check($sformatf("data d%0d p%0d", mon_e.k, mon_e.r), rd_data[mon_e.k][mon_e.r], mon_e.data);
        check($sformatf("written d%0d p%0d", mon_e.k, mon_e.r),
              DW'(rd_written[mon_e.k][mon_e.r]), DW'(mon_e.written));
        seen[mon_e.k][mon_e.r] = 1'b1;
      end
      for (int k = 0; k < ND; k++) begin
        for (int r = 0; r < NR; r++) begin
          if (!seen[k][r]) check($sformatf("idle valid d%0d p%0d", k, r), DW'(rd_valid[k][r]), DW'(0));
        end
        check($sformatf("collision d%0d", k), DW'(coll[k]), DW'(m_coll[k]));
      end
    end
    cyc++;
  end

  // One clock: queue expectations for the current inputs, step the model at the edge.
  task automatic cycle();
    for (int k = 0; k < ND; k++) begin
      for (int r = 0; r < NR; r++) begin
        int a;
        a = int'(rd_addr[r]);
        if (rr_of(k) == 0 && rd_en[r]) begin
          if (a < nregs_of(k)) sb.push_back('{k, r, cyc, m_mem[k][a], m_wr[k][a]});
          else                 sb.push_back('{k, r, cyc, '0, 1'b0});
        end
      end
    end
    for (int k = 0; k < ND; k++) begin
      for (int r = 0; r < NR; r++) begin
        int a;
        logic [DW-1:0] d;
        logic w;
        a = int'(rd_addr[r]);
        d = '0;
        w = 1'b0;
        if (rr_of(k) == 1 && rd_en[r] && !clr) begin
          if (a < nregs_of(k)) begin
            d = m_mem[k][a];
            w = m_wr[k][a];
            if (wb_of(k) == 1) begin
              for (int p = 0; p < NW; p++) begin
                if (wr_en[p] && int'(wr_addr[p]) == a) begin
                  d = wr_data[p];
                  w = 1'b1;
                end
              end
            end
          end
          sb.push_back('{k, r, cyc + 1, d, w});
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < ND; k++) begin
      if (clr) begin
        for (int e = 0; e < 8; e++) begin
          m_mem[k][e] = '0;
          m_wr[k][e]  = 1'b0;
        end
        m_coll[k] = 1'b0;
      end else begin
        m_coll[k] = 1'b0;
        for (int i = 0; i < NW; i++)
          for (int j = i + 1; j < NW; j++)
            if (wr_en[i] && wr_en[j] && wr_addr[i] == wr_addr[j] && int'(wr_addr[i]) < nregs_of(k))
              m_coll[k] = 1'b1;
        for (int p = 0; p < NW; p++) begin
          if (wr_en[p] && int'(wr_addr[p]) < nregs_of(k)) begin
            m_mem[k][int'(wr_addr[p])] = wr_data[p];
            m_wr[k][int'(wr_addr[p])]  = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    clr   = 1'b0;
    wr_en = '0;
    rd_en = '0;
  endtask

  task automatic read_all(input int base);
    rd_en = '1;
    for (int r = 0; r < NR; r++) rd_addr[r] = AW'(base + r);
  endtask

  task automatic randomize_inputs();
    clr   = ($urandom_range(0, 19) == 0);
    wr_en = NW'($urandom());
    rd_en = NR'($urandom());
    for (int p = 0; p < NW; p++) begin
      wr_addr[p] = AW'($urandom_range(0, 7));
      wr_data[p] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : rand_data();
    end
    for (int r = 0; r < NR; r++) rd_addr[r] = AW'($urandom_range(0, 7));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("reset data d%0d", k), DW'(rd_data[k]), '0);
      check($sformatf("reset valid d%0d", k), DW'(rd_valid[k]), '0);
      check($sformatf("reset written d%0d", k), DW'(rd_written[k]), '0);
      check($sformatf("reset collision d%0d", k), DW'(coll[k]), '0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Read all entries after reset, alternating with idle cycles.
    read_all(0); cycle(); idle(); cycle();
    read_all(4); cycle(); idle(); cycle();

    // Two ports on address 3, then distinct addresses, then read back.
    wr_en = 2'b11; wr_addr[0] = 3'd3; wr_addr[1] = 3'd3;
    wr_data[0] = DW'(8'hA5); wr_data[1] = DW'(8'h5A);
    cycle();
    wr_addr[1] = 3'd4; cycle();
    idle(); read_all(2); cycle(); idle(); cycle();

    // Bypass: seed 0x11 at address 2, then overwrite with 0x77 while reading it.
    wr_en = 2'b01; wr_addr[0] = 3'd2; wr_data[0] = DW'(8'h11); cycle();
    wr_data[0] = DW'(8'h77); rd_en = 4'b0001; rd_addr[0] = 3'd2; cycle();
    idle(); cycle();

    // Write 0x3C to address 5 while reading it, then read it again.
    wr_en = 2'b01; wr_addr[0] = 3'd5; wr_data[0] = DW'(8'h3C);
    rd_en = 4'b0001; rd_addr[0] = 3'd5; cycle();
    wr_en = '0; cycle();
    idle(); cycle();

    // Fill every entry, then clear with a concurrent write to address 1.
    for (int i = 0; i < 4; i++) begin
      wr_en = 2'b11;
      wr_addr[0] = AW'(2 * i); wr_addr[1] = AW'(2 * i + 1);
      wr_data[0] = rand_data(); wr_data[1] = rand_data();
      cycle();
    end
    wr_en = 2'b11; wr_addr[0] = 3'd1; wr_addr[1] = 3'd1; read_all(0); clr = 1'b1; cycle();
    idle(); read_all(0); cycle(); read_all(4); cycle(); idle(); cycle();

    // Address 7 is beyond the six-entry variant.
    wr_en = 2'b01; wr_addr[0] = 3'd7; wr_data[0] = rand_data(); cycle();
    wr_en = 2'b11; wr_addr[0] = 3'd6; wr_addr[1] = 3'd6; cycle();
    idle(); read_all(4); cycle(); idle(); cycle();

    for (int n = 0; n < 1500; n++) begin
      randomize_inputs();
      cycle();
    end

    // Reset dropped while registered reads are in flight.
    idle(); read_all(0); cycle();
    mon_en = 1'b0;
    rd_en  = '0;
    rst_n  = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      check($sformatf("async reset valid d%0d", k), DW'(rd_valid[k]), '0);
      check($sformatf("async reset data d%0d", k), DW'(rd_data[k]), '0);
      check($sformatf("async reset collision d%0d", k), DW'(coll[k]), '0);
    end
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      randomize_inputs();
      cycle();
    end
    idle(); cycle();
    @(negedge clk); #1;
    check("scoreboard drained", DW'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
